// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared pipeline types and constants
package npc_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } if_id_state_e;

endpackage

// File: rtl/if_id_reg_if.sv
// rtl/if_id_reg_if.sv - fetch response handshake bundle
interface if_id_reg_if;

  logic                        valid;
  logic                        ready;
  logic [npc_pkg::XLEN-1:0]    pc;
  logic [31:0]                 inst;

  modport master (output valid, output pc, output inst, input ready);
  modport slave  (input valid, input pc, input inst, output ready);

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with one-entry skid buffer
module if_id_reg
  import npc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  if_id_reg_if.slave        ifu,
  input  logic              if_id_stall,
  input  logic              flush,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_pc,
  output logic [31:0]       id_inst
);

  if_id_state_e    state_q, state_d;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic [31:0]     main_inst, skid_inst;

  logic fire, adv;
  logic ld_main_ifu, ld_main_skid, ld_skid;

  // Ready depends on state alone so the fetch handshake never sees stall/flush.
  assign ifu.ready = (state_q != SKID);
  assign id_valid  = (state_q != EMPTY);
  assign id_pc     = main_pc;
  assign id_inst   = id_valid ? main_inst : NOP_INST;

  assign fire = ifu.valid && ifu.ready;
  assign adv  = id_valid && !if_id_stall;

  always_comb begin
    state_d      = state_q;
    ld_main_ifu  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (fire) begin
            state_d     = FULL;
            ld_main_ifu = 1'b1;
          end
        end
        FULL: begin
          if (adv && fire) begin
            ld_main_ifu = 1'b1;
          end else if (adv) begin
            state_d = EMPTY;
          end else if (fire) begin
            state_d = SKID;
            ld_skid = 1'b1;
          end
        end
        SKID: begin
          if (adv) begin
            state_d      = FULL;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_pc   <= '0;
      main_inst <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= NOP_INST;
    end else begin
      state_q <= state_d;
      if (ld_main_ifu) begin
        main_pc   <= ifu.pc;
        main_inst <= ifu.inst;
      end else if (ld_main_skid) begin
        main_pc   <= skid_pc;
        main_inst <= skid_inst;
      end
      if (ld_skid) begin
        skid_pc   <= ifu.pc;
        skid_inst <= ifu.inst;
      end
    end
  end

endmodule

// File: tb/tb_if_id_reg.sv
// tb/tb_if_id_reg.sv - directed self-checking bench for if_id_reg
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_id_stall;
  logic        flush;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;

  int n_tests = 0;
  int n_fail  = 0;

  if_id_reg_if ifu ();

  if_id_reg dut (
    .clk         (clk),
    .rst         (rst),
    .ifu         (ifu),
    .if_id_stall (if_id_stall),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ifu.valid = 1'b0; ifu.pc = '0; ifu.inst = '0;
    if_id_stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", id_valid); end
    n_tests++;
    if (id_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", id_pc); end
    n_tests++;
    if (id_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst got %h want 00000013", id_inst); end
    n_tests++;
    if (ifu.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", ifu.ready); end
  endtask

  task automatic test_streaming();
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
    for (int k = 0; k < 8; k++) begin
      exp_pc   = 64'h8000_0000 + 64'(4 * k);
      exp_inst = 32'h0010_0093 + 32'(k << 20);
      ifu.valid = 1'b1; ifu.pc = exp_pc; ifu.inst = exp_inst;
      tick();
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== exp_inst) begin
        n_fail++;
        $display("FAIL stream_%0d got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, id_valid, id_pc, id_inst, exp_pc, exp_inst);
      end
      n_tests++;
      if (ifu.ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_%0d got %0b want 1", k, ifu.ready); end
    end
    ifu.valid = 1'b0;
  endtask

  task automatic test_bubble_drain();
    ifu.valid = 1'b0; if_id_stall = 1'b0;
    tick();
    n_tests++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %0b want 0", id_valid); end
    n_tests++;
    if (id_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL drain_inst got %h want 00000013", id_inst); end
    n_tests++;
    if (id_pc !== 64'h8000_001C) begin n_fail++; $display("FAIL drain_pc got %h want 8000001c", id_pc); end
  endtask

  task automatic test_stall_skid();
    ifu.valid = 1'b1; ifu.pc = 64'h100; ifu.inst = 32'h0000_0100; if_id_stall = 1'b1;
    tick();
    n_tests++;
    if (id_pc !== 64'h100 || ifu.ready !== 1'b1) begin
      n_fail++; $display("FAIL skid_main got pc=%h rdy=%0b want pc=100 rdy=1", id_pc, ifu.ready);
    end
    ifu.pc = 64'h104; ifu.inst = 32'h0000_0104;
    tick();
    ifu.valid = 1'b0;
    n_tests++;
    if (ifu.ready !== 1'b0 || id_pc !== 64'h100 || id_valid !== 1'b1) begin
      n_fail++; $display("FAIL skid_fill got rdy=%0b pc=%h v=%0b want rdy=0 pc=100 v=1", ifu.ready, id_pc, id_valid);
    end
    tick();
    n_tests++;
    if (ifu.ready !== 1'b0 || id_pc !== 64'h100) begin
      n_fail++; $display("FAIL skid_hold got rdy=%0b pc=%h want rdy=0 pc=100", ifu.ready, id_pc);
    end
    if_id_stall = 1'b0;
    tick();
    n_tests++;
    if (id_pc !== 64'h104 || id_inst !== 32'h0000_0104 || id_valid !== 1'b1 || ifu.ready !== 1'b1) begin
      n_fail++; $display("FAIL skid_release got pc=%h inst=%h v=%0b rdy=%0b want pc=104 inst=00000104 v=1 rdy=1",
                         id_pc, id_inst, id_valid, ifu.ready);
    end
    tick();
    n_tests++;
    if (id_valid !== 1'b0 || id_pc !== 64'h104) begin
      n_fail++; $display("FAIL skid_empty got v=%0b pc=%h want v=0 pc=104", id_valid, id_pc);
    end
  endtask

  task automatic test_flush_skid();
    ifu.valid = 1'b1; ifu.pc = 64'h400; ifu.inst = 32'h0000_0400; if_id_stall = 1'b1;
    tick();
    ifu.pc = 64'h404; ifu.inst = 32'h0000_0404;
    tick();
    ifu.valid = 1'b0;
    n_tests++;
    if (ifu.ready !== 1'b0) begin n_fail++; $display("FAIL flush_skid_pre got rdy=%0b want 0", ifu.ready); end
    flush = 1'b1;
    tick();
    flush = 1'b0; if_id_stall = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0000_0013 || ifu.ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_skid got v=%0b inst=%h rdy=%0b want v=0 inst=00000013 rdy=1",
                         id_valid, id_inst, ifu.ready);
    end
    tick();
    n_tests++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_skid_stays got v=%0b want 0", id_valid); end
  endtask

  task automatic test_flush_fire();
    ifu.valid = 1'b1; ifu.pc = 64'h200; ifu.inst = 32'h0000_0200; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || ifu.ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_fire_drop got v=%0b rdy=%0b want v=0 rdy=1", id_valid, ifu.ready);
    end
    ifu.pc = 64'h300; ifu.inst = 32'h0000_0300;
    tick();
    ifu.valid = 1'b0;
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 64'h300 || id_inst !== 32'h0000_0300) begin
      n_fail++; $display("FAIL flush_fire_next got v=%0b pc=%h inst=%h want v=1 pc=300 inst=00000300",
                         id_valid, id_pc, id_inst);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ifu.valid = 1'b1; ifu.pc = 64'h500; ifu.inst = 32'h0000_0500;
    tick();
    ifu.valid = 1'b0;
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 64'h500) begin
      n_fail++; $display("FAIL rst_mid_pre got v=%0b pc=%h want v=1 pc=500", id_valid, id_pc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || id_pc !== 64'h0 || id_inst !== 32'h0000_0013 || ifu.ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid got v=%0b pc=%h inst=%h rdy=%0b want v=0 pc=0 inst=00000013 rdy=1",
                         id_valid, id_pc, id_inst, ifu.ready);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_bubble_drain();
    test_stall_skid();
    test_flush_skid();
    test_flush_fire();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
